// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-file geometry and preload engine states.
package mips_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   // VERIFY is only reachable when REG_PRELOAD_VERIFY_EN is defined
   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StWrite,
      StVerify,
      StDone
   } preload_state_e;

endpackage

// File: rtl/seq_value_gen.sv
// Arithmetic sequence generator: holds the current register address and value,
// plus the latched range/base/step so the sequence can be replayed.
module seq_value_gen #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic              i_restart,
   input  logic              i_advance,
   input  logic [ADDR_W-1:0] i_first,
   input  logic [ADDR_W-1:0] i_last,
   input  logic [DATA_W-1:0] i_base,
   input  logic [DATA_W-1:0] i_step,
   output logic [ADDR_W-1:0] o_cur,
   output logic [DATA_W-1:0] o_acc,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_first;
   logic [ADDR_W-1:0] r_last;
   logic [DATA_W-1:0] r_base;
   logic [DATA_W-1:0] r_step;
   logic [ADDR_W-1:0] r_cur;
   logic [DATA_W-1:0] r_acc;

   // Load captures a new job, restart rewinds it, advance steps unless at the end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_first <= '0;
         r_last  <= '0;
         r_base  <= '0;
         r_step  <= '0;
         r_cur   <= '0;
         r_acc   <= '0;
      end else if (i_load) begin
         r_first <= i_first;
         r_last  <= i_last;
         r_base  <= i_base;
         r_step  <= i_step;
         r_cur   <= i_first;
         r_acc   <= i_base;
      end else if (i_restart) begin
         r_cur <= r_first;
         r_acc <= r_base;
      end else if (i_advance && !o_last) begin
         // holding at the last element keeps address 31 from wrapping to 0
         r_cur <= r_cur + ADDR_W'(1);
         r_acc <= r_acc + r_step;
      end
   end

   // Current element and end-of-range flag
   always_comb begin
      o_cur  = r_cur;
      o_acc  = r_acc;
      o_last = (r_cur == r_last);
   end

endmodule

// File: rtl/reg_preload_writer.sv
// Register-file preload engine: stalls the pipeline, drains, then writes an
// arithmetic sequence into a register range, one register per cycle.
// Optional readback check of the written range: define REG_PRELOAD_VERIFY_EN.
module reg_preload_writer
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W       = REG_ADDR_W,
   parameter int unsigned DATA_W       = REG_DATA_W,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_first_reg,
   input  logic [ADDR_W-1:0] i_last_reg,
   input  logic [DATA_W-1:0] i_base,
   input  logic [DATA_W-1:0] i_step,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_stall_pipe,
   output logic              o_rf_we,
   output logic [ADDR_W-1:0] o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic [ADDR_W-1:0] o_rf_raddr,
   input  logic [DATA_W-1:0] i_rf_rdata,
   output logic              o_err
);

   localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   preload_state_e r_state, w_state_d;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_last_out;   // element just placed on the write port was the last
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_err;

   logic              w_load, w_restart, w_advance;
   logic              w_we_d;
   logic [ADDR_W-1:0] w_cur;
   logic [DATA_W-1:0] w_acc;
   logic              w_gen_last;

   seq_value_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_gen (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (w_load),
      .i_restart (w_restart),
      .i_advance (w_advance),
      .i_first   (i_first_reg),
      .i_last    (i_last_reg),
      .i_base    (i_base),
      .i_step    (i_step),
      .o_cur     (w_cur),
      .o_acc     (w_acc),
      .o_last    (w_gen_last)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_d;
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_start) w_state_d = (i_first_reg <= i_last_reg) ? StDrain : StDone;
         end
         StDrain: begin
            if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) w_state_d = StWrite;
         end
         StWrite: begin
`ifdef REG_PRELOAD_VERIFY_EN
            if (r_last_out) w_state_d = StVerify;
`else
            if (r_last_out) w_state_d = StDone;
`endif
         end
         StVerify: begin
            if (w_gen_last) w_state_d = StDone;
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Output decode and sequencer control
   always_comb begin
      o_busy       = (r_state != StIdle);
      o_stall_pipe = (r_state != StIdle);
      o_done       = (r_state == StDone);
      w_load       = (r_state == StIdle) && i_start;
`ifdef REG_PRELOAD_VERIFY_EN
      w_restart    = (r_state == StWrite) && (w_state_d == StVerify);
      w_advance    = (w_state_d == StWrite) || (r_state == StVerify);
      o_rf_raddr   = (r_state == StVerify) ? w_cur : '0;
`else
      w_restart    = 1'b0;
      w_advance    = (w_state_d == StWrite);
      o_rf_raddr   = '0;
`endif
      // $zero still consumes its slot and value, it just is never written
      w_we_d       = (w_state_d == StWrite) && (w_cur != ADDR_W'(REG_ZERO));
      o_rf_we      = r_we;
      o_rf_waddr   = r_waddr;
      o_rf_wdata   = r_wdata;
      o_err        = r_err;
   end

   // Drain counter, write-port registers and end-of-range tracking
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_last_out <= 1'b0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
      end else begin
         r_cnt      <= (r_state == StDrain) ? r_cnt + CNT_W'(1) : '0;
         r_last_out <= (w_state_d == StWrite) && w_gen_last;
         r_we       <= w_we_d;
         r_waddr    <= (w_state_d == StWrite) ? w_cur : '0;
         r_wdata    <= (w_state_d == StWrite) ? w_acc : '0;
      end
   end

`ifdef REG_PRELOAD_VERIFY_EN
   logic [DATA_W-1:0] w_expect;
   assign w_expect = (w_cur == ADDR_W'(REG_ZERO)) ? '0 : w_acc;

   // Sticky readback mismatch flag, cleared by the next accepted start
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                                          r_err <= 1'b0;
      else if (w_load)                                       r_err <= 1'b0;
      else if ((r_state == StVerify) && (i_rf_rdata != w_expect)) r_err <= 1'b1;
   end
`else
   logic w_unused_rdata;
   assign w_unused_rdata = ^i_rf_rdata;
   assign r_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_preload_writer.sv
// Directed self-checking bench for reg_preload_writer with a small regfile model.
module tb_reg_preload_writer;

   localparam int DRAIN = 4;
`ifdef REG_PRELOAD_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  first_reg = '0;
   logic [4:0]  last_reg = '0;
   logic [31:0] base = '0;
   logic [31:0] step = '0;
   logic        busy, done, stall_pipe, rf_we, err;
   logic [4:0]  rf_waddr, rf_raddr;
   logic [31:0] rf_wdata, rf_rdata;

   logic [31:0] regs [32];
   bit          corrupt = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   reg_preload_writer #(
      .ADDR_W       (5),
      .DATA_W       (32),
      .DRAIN_CYCLES (DRAIN)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_first_reg  (first_reg),
      .i_last_reg   (last_reg),
      .i_base       (base),
      .i_step       (step),
      .o_busy       (busy),
      .o_done       (done),
      .o_stall_pipe (stall_pipe),
      .o_rf_we      (rf_we),
      .o_rf_waddr   (rf_waddr),
      .o_rf_wdata   (rf_wdata),
      .o_rf_raddr   (rf_raddr),
      .i_rf_rdata   (rf_rdata),
      .o_err        (err)
   );

   // Regfile model; can corrupt r10 to exercise the readback check
   always @(posedge clk) begin
      if (rf_we) regs[rf_waddr] <= (corrupt && rf_waddr == 5'd10) ? rf_wdata ^ 32'h1 : rf_wdata;
   end
   assign rf_rdata = regs[rf_raddr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Run one job from a start pulse; checks every cycle against the expected timeline.
   task automatic run_op(input logic [4:0] f, input logic [4:0] l, input logic [31:0] b,
                         input logic [31:0] s, input int pulse_k, input bit exp_err);
      int n, lat, idx;
      bit wr, vr;
      logic [4:0]  a;
      logic [31:0] d;
      n   = (f <= l) ? int'(l) - int'(f) + 1 : 0;
      lat = (n == 0) ? 1 : DRAIN + n + 1 + (VERIFY ? n : 0);
      @(negedge clk);
      first_reg = f; last_reg = l; base = b; step = s; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      // scramble inputs: the job must use the values latched at start
      first_reg = 5'd3; last_reg = 5'd1; base = 32'hDEAD_BEEF; step = 32'h55;
      for (int k = 1; k <= lat + 2; k++) begin
         wr  = (n > 0) && (k >= DRAIN + 1) && (k <= DRAIN + n);
         vr  = VERIFY && (n > 0) && (k >= DRAIN + n + 1) && (k <= DRAIN + 2 * n);
         idx = wr ? k - DRAIN - 1 : (vr ? k - DRAIN - n - 1 : 0);
         a   = f + 5'(idx);
         d   = b + s * 32'(idx);
         chk($sformatf("stall k%0d", k), {31'b0, stall_pipe}, {31'b0, k <= lat});
         chk($sformatf("busy k%0d", k),  {31'b0, busy},       {31'b0, k <= lat});
         chk($sformatf("done k%0d", k),  {31'b0, done},       {31'b0, k == lat});
         chk($sformatf("we k%0d", k),    {31'b0, rf_we},      {31'b0, wr && a != 5'd0});
         chk($sformatf("waddr k%0d", k), {27'b0, rf_waddr},   wr ? {27'b0, a} : 32'h0);
         chk($sformatf("wdata k%0d", k), rf_wdata,            wr ? d : 32'h0);
         chk($sformatf("raddr k%0d", k), {27'b0, rf_raddr},   vr ? {27'b0, a} : 32'h0);
         if (k >= lat) chk($sformatf("err k%0d", k), {31'b0, err}, {31'b0, exp_err});
         start = (k == pulse_k);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      #22;
      // reset state
      chk("rst busy",  {31'b0, busy},       32'h0);
      chk("rst stall", {31'b0, stall_pipe}, 32'h0);
      chk("rst we",    {31'b0, rf_we},      32'h0);
      chk("rst err",   {31'b0, err},        32'h0);
      rst_n = 1'b1;

      // $t0..$t7 = 4..32, with an ignored start pulse during WRITE
      run_op(5'd8, 5'd15, 32'd4, 32'd4, 7, 1'b0);
      chk("r8",  regs[8],  32'd4);
      chk("r11", regs[11], 32'd16);
      chk("r15", regs[15], 32'd32);
      chk("r16", regs[16], 32'd0);

      // r0 skipped but consumes value 7
      run_op(5'd0, 5'd2, 32'd7, 32'd1, 0, 1'b0);
      chk("r0", regs[0], 32'd0);
      chk("r1", regs[1], 32'd8);
      chk("r2", regs[2], 32'd9);

      // empty range: straight to DONE
      run_op(5'd5, 5'd3, 32'd99, 32'd1, 0, 1'b0);
      chk("r5 untouched", regs[5], 32'd0);

      // value wrap and range ending at r31
      run_op(5'd29, 5'd31, 32'hFFFF_FFFE, 32'd1, 0, 1'b0);
      chk("r29", regs[29], 32'hFFFF_FFFE);
      chk("r30", regs[30], 32'hFFFF_FFFF);
      chk("r31", regs[31], 32'h0);
      chk("r0 after wrap", regs[0], 32'd0);

`ifdef REG_PRELOAD_VERIFY_EN
      // corrupted r10 trips the sticky err; next start clears it
      corrupt = 1'b1;
      run_op(5'd8, 5'd15, 32'd100, 32'd3, 0, 1'b1);
      corrupt = 1'b0;
      repeat (3) @(negedge clk);
      chk("err sticky", {31'b0, err}, 32'h1);
      run_op(5'd5, 5'd3, 32'd0, 32'd0, 0, 1'b0);
      run_op(5'd8, 5'd15, 32'd100, 32'd3, 0, 1'b0);
`endif

      // reset mid-WRITE: outputs drop immediately, no writes afterwards
      @(negedge clk);
      first_reg = 5'd1; last_reg = 5'd20; base = 32'h1000; step = 32'h10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (DRAIN + 3) @(negedge clk);
      chk("pre-rst we", {31'b0, rf_we}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("arst we",    {31'b0, rf_we},      32'h0);
      chk("arst stall", {31'b0, stall_pipe}, 32'h0);
      chk("arst busy",  {31'b0, busy},       32'h0);
      chk("arst waddr", {27'b0, rf_waddr},   32'h0);
      chk("arst wdata", rf_wdata,            32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         chk($sformatf("post-rst we %0d", k),   {31'b0, rf_we}, 32'h0);
         chk($sformatf("post-rst busy %0d", k), {31'b0, busy},  32'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
